// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package    : uart_pkg
//  Description: Shared definitions for the UART receiver: frame defaults,
//               receiver state encoding and the state-LED decode helper.
//  Revision   : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int N_DEF           = 8;    // data bits per frame
  localparam int COUNT_TICKS_DEF = 16;   // oversampling ticks per bit
  localparam int COUNT_DEF       = 131;  // clk cycles per oversampling tick

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // One-hot LED image {STOP,DATA,START,IDLE} of a receiver state.
  function automatic logic [3:0] state_onehot(input state_e st);
    return 4'b0001 << st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : baud_tick_gen
//  Description: Free-running divider; o_tick is high for the single clk in
//               which the counter sits at COUNT-1, then the counter wraps.
//  Revision   : 1.0 - initial release
// ============================================================================
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int COUNT = COUNT_DEF
) (
  input  logic clk,
  input  logic reset,    // asynchronous, active-low
  output logic o_tick
);

  localparam int            CW   = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_baud.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : uart_rx_baud
//  Description: 8N1 UART receiver, LSB first, 16x oversampling, with an
//               integrated baud-tick generator. Emits each received byte on
//               data_out together with a one-clk valid strobe.
//  Options    : UART_RX_FRAMING_CHECK_EN - adds frame_err output; a frame
//               whose stop bit samples low is dropped and flagged instead.
//  Revision   : 1.0 - initial release
// ============================================================================
module uart_rx_baud
  import uart_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int COUNT_TICKS = COUNT_TICKS_DEF,
  parameter int COUNT       = COUNT_DEF
) (
  input  logic         clk,
  input  logic         reset,       // asynchronous, active-low
  input  logic         rx,          // idle high, asynchronous to clk
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         started,
  output logic [3:0]   state_leds,
  output logic         o_tick
`ifdef UART_RX_FRAMING_CHECK_EN
  ,
  output logic         frame_err
`endif
);

  localparam int            SW     = (COUNT_TICKS > 2) ? $clog2(COUNT_TICKS) : 1;
  localparam int            NW     = (N > 2) ? $clog2(N) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(COUNT_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(COUNT_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  logic tick;

  baud_tick_gen #(.COUNT(COUNT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  assign o_tick = tick;

  logic         rx_meta_q, rx_s_q;
  state_e       state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
`ifdef UART_RX_FRAMING_CHECK_EN
  logic         ferr_q, ferr_d;
`endif

  // Two-flop synchronizer for rx; resets to the idle (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic: advances only on baud ticks once a frame has started.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
    ferr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_HALF) begin
            s_d = '0;
            n_d = '0;
            // Still low at mid start bit: a real frame, otherwise a glitch.
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[N-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
            if (!rx_s_q) begin
              ferr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef UART_RX_FRAMING_CHECK_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign started    = (state_q != IDLE);
  assign state_leds = state_onehot(state_q);
`ifdef UART_RX_FRAMING_CHECK_EN
  assign frame_err  = ferr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_baud.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_uart_rx_baud
//  Description: Self-checking bench for uart_rx_baud. A short tick period is
//               used so that a full set of frames stays well inside budget.
//               Honours UART_RX_FRAMING_CHECK_EN for the frame_err port.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_rx_baud;
  import uart_pkg::*;

  localparam int TB_COUNT = 20;
  localparam int TICKS    = 16;
  localparam int BIT_CLK  = TICKS * TB_COUNT;
`ifdef UART_RX_FRAMING_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       started;
  logic [3:0] state_leds;
  logic       o_tick;
`ifdef UART_RX_FRAMING_CHECK_EN
  logic       frame_err;
`endif

  uart_rx_baud #(.N(8), .COUNT_TICKS(TICKS), .COUNT(TB_COUNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .started    (started),
    .state_leds (state_leds),
    .o_tick     (o_tick)
`ifdef UART_RX_FRAMING_CHECK_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  always #25 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int ecount = 0;
  int vdouble = 0;
  logic valid_prev = 1'b0;

  // Count valid / frame_err pulses and catch strobes wider than one clk.
  always @(negedge clk) begin
    if (valid === 1'b1) vcount++;
    if (valid === 1'b1 && valid_prev === 1'b1) vdouble++;
    valid_prev = valid;
`ifdef UART_RX_FRAMING_CHECK_EN
    if (frame_err === 1'b1) ecount++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int len);
    rx = b;
    clks(len);
  endtask

  // Reference transmitter. A bad stop bit is held low for 12 ticks only, so
  // the receiver's final stop sample sees it low but the follow-on start
  // detection is rejected as a glitch rather than starting a phantom frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, output logic mid_started);
    mid_started = 1'b0;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], BIT_CLK);
      if (i == 3) mid_started = started;
    end
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLK);
    end else begin
      send_bit(1'b0, 12 * TB_COUNT);
      send_bit(1'b1, 4 * TB_COUNT);
    end
  endtask

  // Negedges until the next o_tick, bounded.
  task automatic tick_interval(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_tick !== 1'b1 && n < 4 * TB_COUNT);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap_bits;
    logic [7:0] exp_data;
    int         exp_valids;
    int         exp_errs;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  initial begin
    int         iv;
    int         v0;
    int         e0;
    logic       mid;
    logic [7:0] held;

    vec[0] = '{8'h08, 1'b1, 2, 8'h08, 1, 0};
    vec[1] = '{8'h07, 1'b1, 0, 8'h07, 1, 0};
    vec[2] = '{8'h0B, 1'b1, 0, 8'h0B, 1, 0};
    vec[3] = '{8'h52, 1'b1, 2, 8'h52, 1, 0};
    vec[4] = '{8'hFF, 1'b1, 1, 8'hFF, 1, 0};
    vec[5] = '{8'h00, 1'b1, 1, 8'h00, 1, 0};
    vec[6] = '{8'h55, 1'b0, 3, (FCHK ? 8'h00 : 8'h55), (FCHK ? 0 : 1), (FCHK ? 1 : 0)};

    // Reset state.
    clks(3);
    check("rst data_out", {24'd0, data_out}, 32'h00);
    check("rst valid", {31'd0, valid}, 32'd0);
    check("rst started", {31'd0, started}, 32'd0);
    check("rst state_leds", {28'd0, state_leds}, 32'b0001);
    check("rst o_tick", {31'd0, o_tick}, 32'd0);
`ifdef UART_RX_FRAMING_CHECK_EN
    check("rst frame_err", {31'd0, frame_err}, 32'd0);
`endif
    reset = 1'b1;

    // Idle: tick period and quiet outputs.
    tick_interval(iv);
    check("first tick found", {31'd0, o_tick}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick_interval(iv);
      check($sformatf("tick interval %0d", k), iv, TB_COUNT);
    end
    clks(2000);
    @(negedge clk);
    check("idle valids", vcount, 0);
    check("idle state_leds", {28'd0, state_leds}, 32'b0001);
    check("idle started", {31'd0, started}, 32'd0);

    // Table of frames, rows with zero gap are sent back-to-back.
    for (int i = 0; i < NV; i++) begin
      v0 = vcount;
      e0 = ecount;
      send_frame(vec[i].data, vec[i].stop_ok, mid);
      clks(vec[i].gap_bits * BIT_CLK);
      @(negedge clk);
      check($sformatf("row%0d valids", i), vcount - v0, vec[i].exp_valids);
      check($sformatf("row%0d data_out", i), {24'd0, data_out}, {24'd0, vec[i].exp_data});
      check($sformatf("row%0d started mid", i), {31'd0, mid}, 32'd1);
      check($sformatf("row%0d started after", i), {31'd0, started}, 32'd0);
`ifdef UART_RX_FRAMING_CHECK_EN
      check($sformatf("row%0d frame_errs", i), ecount - e0, vec[i].exp_errs);
`endif
    end

    // Short low glitch on rx: rejected, data_out unchanged.
    held = data_out;
    v0 = vcount;
    rx = 1'b0;
    clks(TB_COUNT);
    check("glitch started", {31'd0, started}, 32'd1);
    clks(2 * TB_COUNT);
    rx = 1'b1;
    clks(16 * TB_COUNT);
    @(negedge clk);
    check("glitch valids", vcount - v0, 0);
    check("glitch data_out", {24'd0, data_out}, {24'd0, held});
    check("glitch state_leds", {28'd0, state_leds}, 32'b0001);

    // Reset in the middle of the data bits of 0xA5.
    v0 = vcount;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      iv = (8'hA5 >> i) & 1;
      send_bit(iv[0], BIT_CLK);
    end
    check("abort in DATA", {28'd0, state_leds}, 32'b0100);
    reset = 1'b0;
    #2;
    check("abort state_leds", {28'd0, state_leds}, 32'b0001);
    check("abort started", {31'd0, started}, 32'd0);
    check("abort data_out", {24'd0, data_out}, 32'h00);
    check("abort valid", {31'd0, valid}, 32'd0);
    clks(4);
    rx = 1'b1;
    clks(2);
    reset = 1'b1;
    clks(2 * BIT_CLK);
    check("abort valids", vcount - v0, 0);
    v0 = vcount;
    send_frame(8'h3C, 1'b1, mid);
    clks(BIT_CLK);
    @(negedge clk);
    check("after abort valids", vcount - v0, 1);
    check("after abort data_out", {24'd0, data_out}, 32'h3C);

    check("valid one clk wide", vdouble, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
